// File: rtl/pipe_stage_sequencer.sv
// Single-clock scheduler for a three-stage execute pipeline: issues exec pulses,
// hands tags stage to stage on done, retires from stage 3 and tracks stalls/errors.
module pipe_stage_sequencer #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  output logic [2:0]    exec,
  input  logic [2:0]    done,
  output logic [DW-1:0] s1_data,
  output logic [DW-1:0] s2_data,
  output logic [DW-1:0] s3_data,
  output logic          retire_valid,
  output logic [DW-1:0] retire_data,
  output logic [15:0]   stall_cnt,
  output logic [2:0]    err_timeout,
  output logic [2:0]    err_proto,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } stage_e;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  stage_e          state_q [3];
  stage_e          state_d [3];
  logic [DW-1:0]   data_q  [3];
  logic [DW-1:0]   data_d  [3];
  logic [7:0]      wd_q    [3];
  logic [7:0]      wd_d    [3];

  logic [DW-1:0]   seq_q, seq_d;
  logic [2:0]      exec_q, exec_d;
  logic            retire_valid_q, retire_valid_d;
  logic [DW-1:0]   retire_data_q, retire_data_d;
  logic [15:0]     stall_q, stall_d;
  logic [2:0]      err_timeout_q, err_timeout_d;
  logic [2:0]      err_proto_q, err_proto_d;

  logic [2:0]      in_run, in_hold, in_empty, timeout_hit;
  logic            vac_s1, vac_s2, vac_s3;
  logic [2:0]      vacate, load;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_run[i]      = (state_q[i] == ST_RUN);
      in_hold[i]     = (state_q[i] == ST_HOLD);
      in_empty[i]    = (state_q[i] == ST_EMPTY);
      timeout_hit[i] = in_run[i] && !done[i] && (wd_q[i] >= WD_LAST);
    end
    // A finished stage moves on only into an empty successor or one that is itself moving on.
    vac_s3 = in_hold[2];
    vac_s2 = in_hold[1] && (in_empty[2] || vac_s3);
    vac_s1 = in_hold[0] && (in_empty[1] || vac_s2);
  end

  assign vacate = {vac_s3, vac_s2, vac_s1};
  assign load   = {vac_s2, vac_s1, in_empty[0] && en};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      wd_d[i]    = '0;
    end
    seq_d          = seq_q;
    exec_d         = '0;
    retire_valid_d = 1'b0;
    retire_data_d  = retire_data_q;
    stall_d        = stall_q;
    err_timeout_d  = err_timeout_q;
    err_proto_d    = err_proto_q;

    if (flush) begin
      for (int i = 0; i < 3; i++) begin
        state_d[i] = ST_EMPTY;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        unique case (state_q[i])
          ST_EMPTY: begin
            if (load[i]) state_d[i] = ST_RUN;
          end
          ST_RUN: begin
            if (done[i]) begin
              state_d[i] = ST_HOLD;
            end else if (timeout_hit[i]) begin
              state_d[i]       = ST_EMPTY;
              err_timeout_d[i] = 1'b1;
            end
          end
          ST_HOLD: begin
            if (load[i])        state_d[i] = ST_RUN;
            else if (vacate[i]) state_d[i] = ST_EMPTY;
          end
          default: state_d[i] = ST_EMPTY;
        endcase

        if (done[i] && !in_run[i]) err_proto_d[i] = 1'b1;
        exec_d[i] = (state_d[i] == ST_RUN) && !in_run[i];
        wd_d[i]   = (in_run[i] && (state_d[i] == ST_RUN)) ? wd_q[i] + 8'd1 : '0;
      end

      if (load[0]) begin
        data_d[0] = seq_q;
        seq_d     = seq_q + 1'b1;
      end
      if (load[1]) data_d[1] = data_q[0];
      if (load[2]) data_d[2] = data_q[1];

      if (vacate[2]) begin
        retire_valid_d = 1'b1;
        retire_data_d  = data_q[2];
      end

      if ((|(in_hold & ~vacate)) && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_EMPTY;
        data_q[i]  <= '0;
        wd_q[i]    <= '0;
      end
      seq_q          <= '0;
      exec_q         <= '0;
      retire_valid_q <= 1'b0;
      retire_data_q  <= '0;
      stall_q        <= '0;
      err_timeout_q  <= '0;
      err_proto_q    <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
        wd_q[i]    <= wd_d[i];
      end
      seq_q          <= seq_d;
      exec_q         <= exec_d;
      retire_valid_q <= retire_valid_d;
      retire_data_q  <= retire_data_d;
      stall_q        <= stall_d;
      err_timeout_q  <= err_timeout_d;
      err_proto_q    <= err_proto_d;
    end
  end

  assign exec         = exec_q;
  assign s1_data      = data_q[0];
  assign s2_data      = data_q[1];
  assign s3_data      = data_q[2];
  assign retire_valid = retire_valid_q;
  assign retire_data  = retire_data_q;
  assign stall_cnt    = stall_q;
  assign err_timeout  = err_timeout_q;
  assign err_proto    = err_proto_q;
  assign busy         = |(~in_empty);

endmodule

// File: tb/tb_pipe_stage_sequencer.sv
// Bench for pipe_stage_sequencer: directed phases plus random traffic, every cycle
// compared against a tag-occupancy model of the pipeline.
module tb_pipe_stage_sequencer;

  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          flush;
  logic [2:0]    exec;
  logic [2:0]    done;
  logic [DW-1:0] s1_data, s2_data, s3_data;
  logic          retire_valid;
  logic [DW-1:0] retire_data;
  logic [15:0]   stall_cnt;
  logic [2:0]    err_timeout, err_proto;
  logic          busy;

  pipe_stage_sequencer #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .exec(exec), .done(done),
    .s1_data(s1_data), .s2_data(s2_data), .s3_data(s3_data),
    .retire_valid(retire_valid), .retire_data(retire_data),
    .stall_cnt(stall_cnt), .err_timeout(err_timeout), .err_proto(err_proto),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: which stages hold a tag, which of those have finished, and which just got one.
  logic [2:0] m_has, m_fin, m_fresh, m_err_to, m_err_pr;
  int         m_age [3];
  int         m_tag [3];
  int         m_seq, m_stall, m_rtag;
  logic       m_rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_has = '0; m_fin = '0; m_fresh = '0; m_err_to = '0; m_err_pr = '0;
    for (int i = 0; i < 3; i++) begin
      m_age[i] = 0;
      m_tag[i] = 0;
    end
    m_seq = 0; m_stall = 0; m_rtag = 0; m_rv = 1'b0;
  endtask

  task automatic modelStep(input logic e, input logic f, input logic [2:0] d);
    logic [2:0] leave, nh, nf, nfr;
    int         na [3];
    int         nt [3];
    if (f) begin
      m_has = '0; m_fin = '0; m_fresh = '0; m_rv = 1'b0;
      for (int i = 0; i < 3; i++) m_age[i] = 0;
      return;
    end
    leave[2] = m_has[2] & m_fin[2];
    leave[1] = m_has[1] & m_fin[1] & (~m_has[2] | leave[2]);
    leave[0] = m_has[0] & m_fin[0] & (~m_has[1] | leave[1]);
    if ((|(m_has & m_fin & ~leave)) && m_stall < 65535) m_stall++;
    nh = m_has; nf = m_fin; nfr = '0;
    for (int i = 0; i < 3; i++) begin
      na[i] = m_age[i];
      nt[i] = m_tag[i];
      if (m_has[i] && !m_fin[i]) begin
        if (d[i]) begin
          nf[i] = 1'b1; na[i] = 0;
        end else if (m_age[i] + 1 >= TIMEOUT) begin
          nh[i] = 1'b0; na[i] = 0; m_err_to[i] = 1'b1;
        end else begin
          na[i] = m_age[i] + 1;
        end
      end else if (d[i]) begin
        m_err_pr[i] = 1'b1;
      end
      if (leave[i]) begin
        nh[i] = 1'b0; nf[i] = 1'b0; na[i] = 0;
      end
    end
    m_rv = leave[2];
    if (leave[2]) m_rtag = m_tag[2];
    for (int i = 1; i < 3; i++) begin
      if (leave[i-1]) begin
        nh[i] = 1'b1; nf[i] = 1'b0; na[i] = 0; nt[i] = m_tag[i-1]; nfr[i] = 1'b1;
      end
    end
    if (!m_has[0] && e) begin
      nh[0] = 1'b1; nf[0] = 1'b0; na[0] = 0; nt[0] = m_seq; nfr[0] = 1'b1;
      m_seq = (m_seq + 1) % (1 << DW);
    end
    m_has = nh; m_fin = nf; m_fresh = nfr;
    for (int i = 0; i < 3; i++) begin
      m_age[i] = na[i];
      m_tag[i] = nt[i];
    end
  endtask

  function automatic logic [2:0] runMask();
    return m_has & ~m_fin;
  endfunction

  task automatic checkOutput();
    check("exec", 32'(exec), 32'(m_fresh));
    check("s1_data", 32'(s1_data), m_tag[0]);
    check("s2_data", 32'(s2_data), m_tag[1]);
    check("s3_data", 32'(s3_data), m_tag[2]);
    check("retire_valid", 32'(retire_valid), 32'(m_rv));
    check("retire_data", 32'(retire_data), m_rtag);
    check("stall_cnt", 32'(stall_cnt), m_stall);
    check("err_timeout", 32'(err_timeout), 32'(m_err_to));
    check("err_proto", 32'(err_proto), 32'(m_err_pr));
    check("busy", 32'(busy), 32'(|m_has));
  endtask

  task automatic applyStimulus(input logic e, input logic f, input logic [2:0] d);
    checkOutput();
    en = e; flush = f; done = d;
    modelStep(e, f, d);
    @(negedge clk);
  endtask

  initial begin
    int         hold;
    logic [2:0] d;
    logic       filled;

    rst = 1'b0; en = 1'b0; flush = 1'b0; done = '0;
    modelReset();
    repeat (3) @(negedge clk);
    check("rst_exec", 32'(exec), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_retire", 32'(retire_valid), 0);
    check("rst_s1", 32'(s1_data), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    check("rst_err", 32'({err_timeout, err_proto}), 0);
    rst = 1'b1;

    // Zero-wait stages: done follows exec directly.
    for (int k = 0; k < 16; k++) begin
      if (k == 1) check("first_exec", 32'(exec), 32'h1);
      if (k == 7 || k == 10 || k == 13) begin
        check("zw_retire_valid", 32'(retire_valid), 1);
        check("zw_retire_tag", 32'(retire_data), (k - 7) / 3);
      end
      applyStimulus(1'b1, 1'b0, exec);
    end
    check("zw_stall", 32'(stall_cnt), 0);

    // Stage 3 withholds done for five cycles, backing up stages 2 and 1.
    hold = 5;
    for (int k = 0; k < 24; k++) begin
      d = runMask();
      if (d[2] && hold > 0) begin d[2] = 1'b0; hold--; end
      applyStimulus(1'b1, 1'b0, d);
    end
    check("stall_grew", 32'(stall_cnt != 16'd0), 1);

    // Stage 2 never finishes its tag and must be dropped by the watchdog.
    hold = TIMEOUT + 1;
    for (int k = 0; k < 40; k++) begin
      d = runMask();
      if (d[1] && hold > 0) begin d[1] = 1'b0; hold--; end
      applyStimulus(1'b1, 1'b0, d);
    end
    check("timeout_stage2", 32'(err_timeout), 32'h2);

    // Fill all three stages, then flush.
    filled = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_has == 3'b111) begin filled = 1'b1; break; end
      d = runMask();
      d[2] = 1'b0;
      applyStimulus(1'b1, 1'b0, d);
    end
    check("fill_before_flush", 32'(filled), 1);
    applyStimulus(1'b1, 1'b1, 3'b000);
    check("flush_busy", 32'(busy), 0);
    check("flush_retire", 32'(retire_valid), 0);
    check("flush_exec", 32'(exec), 0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, runMask());

    // Drain with en low, then a stray done on the empty first stage.
    for (int k = 0; k < 30; k++) applyStimulus(1'b0, 1'b0, runMask());
    check("drained_busy", 32'(busy), 0);
    applyStimulus(1'b0, 1'b0, 3'b001);
    check("proto_err", 32'(err_proto), 32'h1);
    check("proto_exec", 32'(exec), 0);
    check("proto_busy", 32'(busy), 0);
    applyStimulus(1'b0, 1'b0, 3'b000);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      d = runMask();
      for (int i = 0; i < 3; i++) begin
        if (d[i]) d[i] = ($urandom_range(0, 9) < 6);
        else      d[i] = ($urandom_range(0, 99) < 2);
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, d);
    end

    // Asynchronous reset between edges.
    #3 rst = 1'b0;
    #1;
    check("arst_exec", 32'(exec), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_retire_valid", 32'(retire_valid), 0);
    check("arst_retire_data", 32'(retire_data), 0);
    check("arst_data", 32'({s1_data, s2_data, s3_data}), 0);
    check("arst_stall", 32'(stall_cnt), 0);
    check("arst_err_timeout", 32'(err_timeout), 0);
    check("arst_err_proto", 32'(err_proto), 0);
    modelReset();
    done = '0; en = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) check("restart_exec", 32'(exec), 32'h1);
      if (k == 4) check("restart_seq", 32'(s1_data), 1);
      applyStimulus(1'b1, 1'b0, exec);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
